// File: rtl/lfsr_period_checker.sv
// Period monitor for a small LFSR: captures a seed sample, counts
// valid samples until it recurs, and flags lock-up or timeout.
module lfsr_period_checker #(
  parameter int WIDTH = 6,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic             maxlen,
  output logic             lockup,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(1) << WIDTH;
  localparam logic [CNT_W-1:0] MAXP = FULL - CNT_W'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] seed, seed_n;
  logic [CNT_W-1:0] count, count_n;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] period_n;
  logic             maxlen_n;
  logic             lockup_n;
  logic             timeout_n;
  logic             is_zero;

  assign busy    = (state == ARM) || (state == COUNT);
  assign done    = (state == DONE);
  assign is_zero = (data_in == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      seed    <= '0;
      count   <= '0;
      period  <= '0;
      maxlen  <= 1'b0;
      lockup  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      seed    <= seed_n;
      count   <= count_n;
      period  <= period_n;
      maxlen  <= maxlen_n;
      lockup  <= lockup_n;
      timeout <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    seed_n    = seed;
    count_n   = count;
    period_n  = period;
    maxlen_n  = maxlen;
    lockup_n  = lockup;
    timeout_n = timeout;
    count_inc = count + CNT_W'(1);
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n   = ARM;
          period_n  = '0;
          maxlen_n  = 1'b0;
          lockup_n  = 1'b0;
          timeout_n = 1'b0;
        end
      end
      ARM: begin
        if (valid_in) begin
          seed_n  = data_in;
          count_n = '0;
          if (is_zero) begin
            state_n  = DONE;
            lockup_n = 1'b1;
            period_n = '0;
          end else begin
            state_n = COUNT;
          end
        end
      end
      COUNT: begin
        // Zero beats seed match; timeout only if neither fired.
        if (valid_in) begin
          if (is_zero) begin
            state_n  = DONE;
            lockup_n = 1'b1;
            period_n = '0;
          end else if (data_in == seed) begin
            state_n  = DONE;
            period_n = count_inc;
            maxlen_n = (count_inc == MAXP);
          end else if (count_inc == FULL) begin
            state_n   = DONE;
            timeout_n = 1'b1;
            period_n  = '0;
          end else begin
            count_n = count_inc;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
